// File: rtl/time_set_ctrl_pkg.sv
// Shared types, limits and button indices for the clock time-set controller.
// The wrap helper is used for both the hour and the minute edit fields.
package chasy_pkg;

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, COMMIT} set_state_t;

  localparam int HOUR_MAX   = 23;
  localparam int MIN_MAX    = 59;
  localparam int NUM_BTN    = 4;
  localparam int BTN_MODE   = 3;
  localparam int BTN_INC    = 2;
  localparam int BTN_DEC    = 1;
  localparam int BTN_CANCEL = 0;

  // Any value above max (out-of-range capture) wraps back into range on the first step.
  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max,
                                           input logic up);
    if (up) return (v >= max) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0 || v > max) ? max : v - 6'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Bus between the time-set controller and the hh:mm:ss counter / display.
// The controller is the master: it drives gating, load and edit status.
interface time_set_ctrl_if;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic       tick_en;
  logic       load;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic [1:0] edit_field;
  logic       blink;

  modport master (input cur_hour, cur_min,
                  output tick_en, load, load_hour, load_min, load_sec, edit_field, blink);
  modport slave  (output cur_hour, cur_min,
                  input tick_en, load, load_hour, load_min, load_sec, edit_field, blink);
endinterface

// File: rtl/time_set_ctrl_debounce.sv
// One button: 2-FF synchronizer, counting debouncer, rising-edge pulse.
// The pulse is combinational off the debounced level so press latency is 2+N+1.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2, level, level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_d <= level;
      // Count consecutive samples that disagree with the accepted level.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/time_set_ctrl.sv
// Panel-button mode controller: RUN / SET_HOUR / SET_MIN / COMMIT, edit regs,
// idle timeout and blink phase for the display of the field being edited.
module time_set_ctrl
  import chasy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250,
  parameter int BLINK_DIV       = 256,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [0:NUM_BTN-1]    button,
  time_set_ctrl_if.master       bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [NUM_BTN-1:0] ev;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock (clock),
      .reset (reset),
      .raw   (button[i]),
      .pulse (ev[i])
    );
  end

  // Only the highest-priority event of a cycle acts.
  logic act_mode, act_cancel, act_inc, act_dec;
  assign act_mode   = ev[BTN_MODE];
  assign act_cancel = ev[BTN_CANCEL] & ~act_mode;
  assign act_inc    = ev[BTN_INC]    & ~act_mode & ~act_cancel;
  assign act_dec    = ev[BTN_DEC]    & ~act_mode & ~act_cancel & ~act_inc;

  set_state_t    state, nxt;
  logic [4:0]    edit_hour, nxt_hour, out_hour;
  logic [5:0]    edit_min, nxt_min, out_min;
  logic [TW-1:0] tmo;
  logic [BW-1:0] bcnt;
  logic          blink_q, accepted, tmo_hit, in_set;

  assign tmo_hit = (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign in_set  = (state == SET_HOUR) || (state == SET_MIN);

  always_comb begin
    nxt      = state;
    nxt_hour = edit_hour;
    nxt_min  = edit_min;
    accepted = 1'b0;
    unique case (state)
      RUN: begin
        if (act_mode) begin
          nxt      = SET_HOUR;
          nxt_hour = bus.cur_hour;
          nxt_min  = bus.cur_min;
        end
      end
      SET_HOUR: begin
        accepted = act_mode | act_cancel | act_inc | act_dec;
        if (act_mode)        nxt = SET_MIN;
        else if (act_cancel) nxt = RUN;
        else if (act_inc)    nxt_hour = 5'(step_wrap({1'b0, edit_hour}, 6'(HOUR_MAX), 1'b1));
        else if (act_dec)    nxt_hour = 5'(step_wrap({1'b0, edit_hour}, 6'(HOUR_MAX), 1'b0));
        else if (tmo_hit)    nxt = RUN;
      end
      SET_MIN: begin
        accepted = act_mode | act_cancel | act_inc | act_dec;
        if (act_mode)        nxt = COMMIT;
        else if (act_cancel) nxt = RUN;
        else if (act_inc)    nxt_min = step_wrap(edit_min, 6'(MIN_MAX), 1'b1);
        else if (act_dec)    nxt_min = step_wrap(edit_min, 6'(MIN_MAX), 1'b0);
        else if (tmo_hit)    nxt = RUN;
      end
      default: nxt = RUN;
    endcase
  end

  always_comb begin
    bus.tick_en    = (state == RUN);
    bus.load       = (state == COMMIT);
    bus.load_hour  = out_hour;
    bus.load_min   = out_min;
    bus.load_sec   = '0;
    bus.edit_field = 2'd0;
    bus.blink      = blink_q & in_set;
    if (state == SET_HOUR) bus.edit_field = 2'd1;
    if (state == SET_MIN)  bus.edit_field = 2'd2;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      edit_hour <= '0;
      edit_min  <= '0;
      out_hour  <= '0;
      out_min   <= '0;
    end else begin
      state     <= nxt;
      edit_hour <= nxt_hour;
      edit_min  <= nxt_min;
      // Load values are latched on the way into COMMIT and held until the next one.
      if (state == SET_MIN && nxt == COMMIT) begin
        out_hour <= edit_hour;
        out_min  <= edit_min;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo     <= '0;
      bcnt    <= '0;
      blink_q <= 1'b0;
    end else begin
      if (!in_set || accepted || nxt != state) tmo <= '0;
      else                                     tmo <= tmo + TW'(1);
      if (nxt != state && (nxt == SET_HOUR || nxt == SET_MIN)) begin
        bcnt    <= '0;
        blink_q <= 1'b1;
      end else if (bcnt == BW'(BLINK_DIV - 1)) begin
        bcnt    <= '0;
        blink_q <= ~blink_q;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: editing flow, wraps, bounce, priority,
// idle timeout, blink phase and reset during an edit.
module tb_time_set_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:3] button = '0;
  int         pass_cnt = 0;
  int         total = 0;
  int         load_cnt = 0;
  int         lh, lm, ls, lt;

  time_set_ctrl_if bus();

  time_set_ctrl dut (.clock(clk), .reset(rst), .button(button), .bus(bus));

  always #1 clk = ~clk;

  // Record every cycle that load is high, with the values presented.
  always @(negedge clk) begin
    if (bus.load === 1'b1) begin
      load_cnt <= load_cnt + 1;
      lh <= int'(bus.load_hour);
      lm <= int'(bus.load_min);
      ls <= int'(bus.load_sec);
      lt <= int'(bus.tick_en);
    end
  end

  task automatic press(input bit m, input bit i, input bit d, input bit c);
    @(negedge clk);
    button[3] = m; button[2] = i; button[1] = d; button[0] = c;
    repeat (300) @(negedge clk);
    button = '0;
    repeat (300) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; button = '0; bus.cur_hour = 5'd0; bus.cur_min = 6'd0;
    repeat (3) @(negedge clk);
    total++; if (bus.tick_en !== 1'b1) $display("FAIL rst_tick: got %0d exp 1", bus.tick_en); else pass_cnt++;
    total++; if (bus.load !== 1'b0) $display("FAIL rst_load: got %0d exp 0", bus.load); else pass_cnt++;
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    total++; if (bus.tick_en !== 1'b1) $display("FAIL idle_tick: got %0d exp 1", bus.tick_en); else pass_cnt++;
    total++; if (bus.edit_field !== 2'd0) $display("FAIL idle_field: got %0d exp 0", bus.edit_field); else pass_cnt++;
    total++; if (bus.blink !== 1'b0) $display("FAIL idle_blink: got %0d exp 0", bus.blink); else pass_cnt++;
    total++; if (load_cnt != 0) $display("FAIL idle_load: got %0d exp 0", load_cnt); else pass_cnt++;
    total++; if ({bus.load_hour, bus.load_min, bus.load_sec} !== 17'd0) $display("FAIL idle_vals: got %0d:%0d:%0d exp 0:0:0", bus.load_hour, bus.load_min, bus.load_sec); else pass_cnt++;
  endtask

  task automatic test_edit_flow();
    int base;
    base = load_cnt;
    bus.cur_hour = 5'd7; bus.cur_min = 6'd45;
    press(1, 0, 0, 0);
    total++; if (bus.tick_en !== 1'b0 || bus.edit_field !== 2'd1) $display("FAIL flow_sethour: got tick %0d field %0d exp 0 1", bus.tick_en, bus.edit_field); else pass_cnt++;
    repeat (3) press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    total++; if (bus.tick_en !== 1'b0 || bus.edit_field !== 2'd2) $display("FAIL flow_setmin: got tick %0d field %0d exp 0 2", bus.tick_en, bus.edit_field); else pass_cnt++;
    repeat (2) press(0, 0, 1, 0);
    total++; if (load_cnt != base || bus.tick_en !== 1'b0) $display("FAIL flow_preload: got loads %0d tick %0d exp %0d 0", load_cnt, bus.tick_en, base); else pass_cnt++;
    press(1, 0, 0, 0);
    total++; if (load_cnt != base + 1) $display("FAIL flow_pulse: got %0d load cycles exp 1", load_cnt - base); else pass_cnt++;
    total++; if (lh != 10 || lm != 43 || ls != 0) $display("FAIL flow_value: got %0d:%0d:%0d exp 10:43:0", lh, lm, ls); else pass_cnt++;
    total++; if (lt != 0) $display("FAIL flow_tick_at_load: got %0d exp 0", lt); else pass_cnt++;
    total++; if (bus.tick_en !== 1'b1 || bus.edit_field !== 2'd0) $display("FAIL flow_after: got tick %0d field %0d exp 1 0", bus.tick_en, bus.edit_field); else pass_cnt++;
    total++; if (bus.load_hour !== 5'd10 || bus.load_min !== 6'd43) $display("FAIL flow_hold: got %0d:%0d exp 10:43", bus.load_hour, bus.load_min); else pass_cnt++;
  endtask

  task automatic test_wrap();
    bus.cur_hour = 5'd23; bus.cur_min = 6'd0;
    press(1, 0, 0, 0); press(0, 1, 0, 0); press(1, 0, 0, 0); press(0, 0, 1, 0); press(1, 0, 0, 0);
    total++; if (lh != 0 || lm != 59) $display("FAIL wrap_h23_m0: got %0d:%0d exp 0:59", lh, lm); else pass_cnt++;
    bus.cur_hour = 5'd5; bus.cur_min = 6'd59;
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(0, 1, 0, 0); press(1, 0, 0, 0);
    total++; if (lh != 5 || lm != 0) $display("FAIL wrap_m59: got %0d:%0d exp 5:0", lh, lm); else pass_cnt++;
    bus.cur_hour = 5'd30; bus.cur_min = 6'd62;
    press(1, 0, 0, 0); press(0, 0, 1, 0); press(1, 0, 0, 0); press(0, 1, 0, 0); press(1, 0, 0, 0);
    total++; if (lh != 23 || lm != 0) $display("FAIL wrap_outrange: got %0d:%0d exp 23:0", lh, lm); else pass_cnt++;
  endtask

  task automatic test_bounce();
    bus.cur_hour = 5'd10; bus.cur_min = 6'd20;
    press(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); button[2] = ~button[2];
      repeat (99) @(negedge clk);
    end
    button[2] = 1'b1;
    repeat (300) @(negedge clk);
    button[2] = 1'b0;
    repeat (300) @(negedge clk);
    press(1, 0, 0, 0); press(1, 0, 0, 0);
    total++; if (lh != 11 || lm != 20) $display("FAIL bounce_once: got %0d:%0d exp 11:20", lh, lm); else pass_cnt++;
  endtask

  task automatic test_priority();
    int base;
    base = load_cnt;
    bus.cur_hour = 5'd12; bus.cur_min = 6'd34;
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(0, 0, 0, 1);
    total++; if (bus.tick_en !== 1'b1 || bus.edit_field !== 2'd0 || load_cnt != base) $display("FAIL cancel_min: got tick %0d field %0d loads %0d exp 1 0 %0d", bus.tick_en, bus.edit_field, load_cnt, base); else pass_cnt++;
    press(1, 0, 0, 0); press(0, 1, 0, 1);
    total++; if (bus.tick_en !== 1'b1 || load_cnt != base) $display("FAIL cancel_over_inc: got tick %0d loads %0d exp 1 %0d", bus.tick_en, load_cnt, base); else pass_cnt++;
    press(1, 1, 0, 0);
    total++; if (bus.edit_field !== 2'd1) $display("FAIL modeinc_run: got field %0d exp 1", bus.edit_field); else pass_cnt++;
    press(1, 1, 0, 0);
    total++; if (bus.edit_field !== 2'd2) $display("FAIL modeinc_hour: got field %0d exp 2", bus.edit_field); else pass_cnt++;
    press(1, 0, 1, 0);
    total++; if (load_cnt != base + 1 || lh != 12 || lm != 34) $display("FAIL mode_priority_val: got %0d loads %0d:%0d exp 1 12:34", load_cnt - base, lh, lm); else pass_cnt++;
  endtask

  task automatic test_timeout_reset();
    int base;
    base = load_cnt;
    @(negedge clk);
    button[3] = 1'b1;
    for (int n = 1; n <= 50260; n++) begin
      @(negedge clk);
      if (n == 300) button[3] = 1'b0;
      if (n == 252) begin
        total++; if (bus.tick_en !== 1'b1) $display("FAIL latency_early: got tick %0d exp 1", bus.tick_en); else pass_cnt++;
      end
      if (n == 253) begin
        total++; if (bus.tick_en !== 1'b0 || bus.edit_field !== 2'd1 || bus.blink !== 1'b1) $display("FAIL latency_enter: got tick %0d field %0d blink %0d exp 0 1 1", bus.tick_en, bus.edit_field, bus.blink); else pass_cnt++;
      end
      if (n == 508) begin
        total++; if (bus.blink !== 1'b1) $display("FAIL blink_hold: got %0d exp 1", bus.blink); else pass_cnt++;
      end
      if (n == 509) begin
        total++; if (bus.blink !== 1'b0) $display("FAIL blink_toggle: got %0d exp 0", bus.blink); else pass_cnt++;
      end
      if (n == 50252) begin
        total++; if (bus.edit_field !== 2'd1) $display("FAIL timeout_early: got field %0d exp 1", bus.edit_field); else pass_cnt++;
      end
      if (n == 50253) begin
        total++; if (bus.edit_field !== 2'd0 || bus.tick_en !== 1'b1 || bus.blink !== 1'b0) $display("FAIL timeout_run: got field %0d tick %0d blink %0d exp 0 1 0", bus.edit_field, bus.tick_en, bus.blink); else pass_cnt++;
      end
    end
    total++; if (load_cnt != base) $display("FAIL timeout_noload: got %0d exp %0d", load_cnt, base); else pass_cnt++;
    bus.cur_hour = 5'd3; bus.cur_min = 6'd3;
    press(1, 0, 0, 0); press(1, 0, 0, 0);
    total++; if (bus.edit_field !== 2'd2) $display("FAIL pre_reset_field: got %0d exp 2", bus.edit_field); else pass_cnt++;
    @(negedge clk); rst = 1'b1; #0.5;
    total++; if (bus.tick_en !== 1'b1 || bus.load !== 1'b0 || bus.edit_field !== 2'd0 || bus.blink !== 1'b0) $display("FAIL midreset_ctl: got tick %0d load %0d field %0d blink %0d exp 1 0 0 0", bus.tick_en, bus.load, bus.edit_field, bus.blink); else pass_cnt++;
    total++; if (bus.load_hour !== 5'd0 || bus.load_min !== 6'd0 || bus.load_sec !== 6'd0) $display("FAIL midreset_vals: got %0d:%0d:%0d exp 0:0:0", bus.load_hour, bus.load_min, bus.load_sec); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    total++; if (load_cnt != base || bus.tick_en !== 1'b1) $display("FAIL post_reset: got loads %0d tick %0d exp %0d 1", load_cnt, bus.tick_en, base); else pass_cnt++;
  endtask

  initial begin
    bus.cur_hour = 5'd0; bus.cur_min = 6'd0;
    test_reset();
    test_edit_flow();
    test_wrap();
    test_bounce();
    test_priority();
    test_timeout_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
